// File: rtl/sub_bytes_engine_pkg.sv
// Shared AES byte/state types, forward and inverse S-box tables, and the
// legal-lane check for the sub_bytes_engine block.
package sub_bytes_engine_pkg;

  typedef logic [7:0]             t_opaque_AESByte;
  // Byte k sits at state[k/4][k%4], i.e. bits [8k+7:8k].
  typedef logic [3:0][3:0][7:0]   t_opaque_AESState;

  localparam logic [0:255][7:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic bit lanes_legal(int unsigned lanes);
    return lanes inside {1, 2, 4, 8, 16};
  endfunction

endpackage

// File: rtl/sbox_dual.sv
// Single-byte S-box lane: forward or inverse table lookup, purely combinational.
module sbox_dual
  import sub_bytes_engine_pkg::*;
(
  input  logic [7:0] byte_i,
  input  logic       inv,
  output logic [7:0] byte_o
);

  always_comb begin
    byte_o = inv ? SBOX_INV[byte_i] : SBOX_FWD[byte_i];
  end

endmodule

// File: rtl/sub_bytes_engine.sv
// Iterative AES SubBytes/InvSubBytes engine: LANES bytes substituted per cycle,
// valid/ready handshake on both sides, result held until downstream accepts.
module sub_bytes_engine
  import sub_bytes_engine_pkg::*;
#(
  parameter  int unsigned LANES = 4,
  localparam int unsigned STEPS = 16 / LANES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  localparam int unsigned STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (!lanes_legal(LANES)) begin : g_bad_lanes
    $error("sub_bytes_engine: LANES must be one of 1, 2, 4, 8, 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q, state_d;
  t_opaque_AESState  work_q, work_d;
  logic              inv_q, inv_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              out_valid_q, out_valid_d;

  logic [3:0]        base;
  t_opaque_AESByte   lane_out [LANES];
  logic [3:0]        idx;

  always_comb begin
    base = 4'(step_q * LANES);
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [3:0] lane_idx;
    assign lane_idx = 4'(base + l);
    sbox_dual u_sbox (
      .byte_i (work_q[lane_idx[3:2]][lane_idx[1:0]]),
      .inv    (inv_q),
      .byte_o (lane_out[l])
    );
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    inv_d    = inv_q;
    step_d   = step_q;
    in_ready = 1'b0;
    idx      = '0;
    unique case (state_q)
      IDLE: in_ready = 1'b1;
      RUN: begin
        for (int unsigned l = 0; l < LANES; l++) begin
          idx = 4'(base + l);
          work_d[idx[3:2]][idx[1:0]] = lane_out[l];
        end
        if (step_q == STEP_W'(STEPS - 1)) begin
          state_d = DONE;
          step_d  = '0;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      DONE: begin
        // A pending block may be taken on the same edge the result leaves.
        in_ready = out_ready;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (in_valid && in_ready) begin
      state_d = RUN;
      work_d  = in_state;
      inv_d   = in_inv;
      step_d  = '0;
    end
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      inv_q       <= 1'b0;
      step_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      inv_q       <= inv_d;
      step_q      <= step_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_state = work_q;

endmodule
